// File: rtl/block_dispatcher.sv
// Splits a kernel's thread count into fixed-size blocks and farms them out to
// a small core array, recycling each core through a one-cycle reset.
module block_dispatcher #(
  parameter  int NUM_CORES         = 2,
  parameter  int THREADS_PER_BLOCK = 4,
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [7:0]                    thread_count,
  input  logic [NUM_CORES-1:0]          core_done,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES-1:0]          core_reset,
  output logic [NUM_CORES-1:0][7:0]     core_block_id,
  output logic [NUM_CORES-1:0][TCW-1:0] core_thread_count,
  output logic                          done
);

  localparam int        LG   = $clog2(THREADS_PER_BLOCK);
  localparam logic [8:0] TPB9 = 9'(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]                    r_tc;
  logic [7:0]                    r_total;
  logic [7:0]                    r_disp;
  logic [7:0]                    r_comp;
  logic [NUM_CORES-1:0]          r_start;
  logic [NUM_CORES-1:0]          r_rst;
  logic [NUM_CORES-1:0][7:0]     r_bid;
  logic [NUM_CORES-1:0][TCW-1:0] r_cnt;

  logic [7:0]           w_total;
  logic                 w_launch;
  logic                 w_avail;
  logic [NUM_CORES-1:0] w_cmp;
  logic [NUM_CORES-1:0] w_sel;
  logic [7:0]           w_ncmp;
  logic [8:0]           w_rem;
  logic [TCW-1:0]       w_cnt;

  // 9-bit sum so tc=255 rounds up without wrapping
  assign w_total  = 8'(({1'b0, thread_count} + TPB9 - 9'd1) >> LG);
  assign w_launch = (r_state == S_IDLE) && start;

  assign core_start        = r_start;
  assign core_reset        = r_rst;
  assign core_block_id     = r_bid;
  assign core_thread_count = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_LAUNCH;
      S_LAUNCH: w_next = (r_tc == 8'd0) ? S_DONE : S_RUN;
      S_RUN:    if (r_comp == r_total) w_next = S_DONE;
      S_DONE:   if (!start) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    done    = (r_state == S_DONE);
    w_avail = ((r_state == S_LAUNCH) || (r_state == S_RUN))
              && (r_disp < r_total);
    w_cmp   = (r_state == S_RUN) ? (core_done & r_start) : '0;
    w_ncmp  = '0;
    w_sel   = '0;
    // every core is being reset during launch, so all count as free there
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      w_ncmp = w_ncmp + 8'(w_cmp[i]);
      if (w_avail && ((r_state == S_LAUNCH) || (!r_start[i] && !r_rst[i]))) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
    w_rem = {1'b0, r_tc} - ({1'b0, r_disp} << LG);
    w_cnt = (w_rem >= TPB9) ? TCW'(THREADS_PER_BLOCK) : w_rem[TCW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tc    <= '0;
      r_total <= '0;
      r_disp  <= '0;
      r_comp  <= '0;
      r_start <= '0;
      r_rst   <= '0;
      r_bid   <= '0;
      r_cnt   <= '0;
    end else if (w_launch) begin
      r_tc    <= thread_count;
      r_total <= w_total;
      r_disp  <= '0;
      r_comp  <= '0;
      r_start <= '0;
      r_rst   <= '1;
    end else begin
      r_start <= (r_start & ~w_cmp) | w_sel;
      r_rst   <= w_cmp;
      r_comp  <= r_comp + w_ncmp;
      if (|w_sel) r_disp <= r_disp + 8'd1;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_sel[i]) begin
          r_bid[i] <= r_disp;
          r_cnt[i] <= w_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher: launch latency, partial last block,
// empty kernel, simultaneous completion, async reset and a 255-thread run.
module tb_block_dispatcher;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TCW = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic [7:0]             thread_count = '0;
  logic [NC-1:0]          core_done = '0;
  logic [NC-1:0]          core_start;
  logic [NC-1:0]          core_reset;
  logic [NC-1:0][7:0]     core_block_id;
  logic [NC-1:0][TCW-1:0] core_thread_count;
  logic                   done;

  int n_chk = 0;
  int n_err = 0;

  block_dispatcher #(
    .NUM_CORES(NC),
    .THREADS_PER_BLOCK(TPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .thread_count(thread_count),
    .core_done(core_done),
    .core_start(core_start),
    .core_reset(core_reset),
    .core_block_id(core_block_id),
    .core_thread_count(core_thread_count),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NC-1:0] prev;
  int n_disp;
  int last_bid;
  int cnt62;
  int cnt63;

  initial begin
    repeat (2) tick();
    chk("rst_start", 32'(core_start), 0);
    chk("rst_reset", 32'(core_reset), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bid", 32'(core_block_id), 0);
    chk("rst_cnt", 32'(core_thread_count), 0);
    reset = 1'b1;
    tick();

    // tc=8: two full blocks
    thread_count = 8'd8;
    start = 1'b1;
    tick();
    chk("t1_launch_rst", 32'(core_reset), 3);
    chk("t1_launch_start", 32'(core_start), 0);
    tick();
    chk("t1_c0_start", 32'(core_start), 1);
    chk("t1_c0_bid", 32'(core_block_id[0]), 0);
    chk("t1_c0_cnt", 32'(core_thread_count[0]), 4);
    chk("t1_rst_clr", 32'(core_reset), 0);
    tick();
    chk("t1_c1_start", 32'(core_start), 3);
    chk("t1_c1_bid", 32'(core_block_id[1]), 1);
    chk("t1_c1_cnt", 32'(core_thread_count[1]), 4);
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    chk("t1_c0_fin", 32'(core_start), 2);
    chk("t1_c0_rst", 32'(core_reset), 1);
    tick();
    chk("t1_no_third", 32'(core_start), 2);
    chk("t1_rst_pulse", 32'(core_reset), 0);
    core_done = 2'b10;
    tick();
    core_done = 2'b00;
    chk("t1_c1_fin", 32'(core_start), 0);
    chk("t1_done_lo", 32'(done), 0);
    tick();
    chk("t1_done_hi", 32'(done), 1);
    chk("t1_idle_cores", 32'(core_start), 0);
    chk("t1_bid_hold", 32'(core_block_id[1]), 1);
    start = 1'b0;
    tick();
    chk("t1_done_fall", 32'(done), 0);

    // tc=10: partial third block
    thread_count = 8'd10;
    start = 1'b1;
    tick();
    tick();
    chk("t2_c0_start", 32'(core_start), 1);
    tick();
    chk("t2_c1_start", 32'(core_start), 3);
    core_done = 2'b10;
    tick();
    core_done = 2'b00;
    chk("t2_c1_fin", 32'(core_start), 1);
    tick();
    chk("t2_c1_busy", 32'(core_start), 1);
    tick();
    chk("t2_redisp", 32'(core_start), 3);
    chk("t2_b2_bid", 32'(core_block_id[1]), 2);
    chk("t2_b2_cnt", 32'(core_thread_count[1]), 2);
    chk("t2_c0_bid", 32'(core_block_id[0]), 0);
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    chk("t2_c0_fin", 32'(core_start), 2);
    chk("t2_done_2of3", 32'(done), 0);
    core_done = 2'b10;
    tick();
    core_done = 2'b00;
    chk("t2_all_fin", 32'(core_start), 0);
    chk("t2_done_lo", 32'(done), 0);
    tick();
    chk("t2_done_hi", 32'(done), 1);
    start = 1'b0;
    tick();

    // tc=0: straight to done
    thread_count = 8'd0;
    start = 1'b1;
    tick();
    chk("t3_launch_done", 32'(done), 0);
    chk("t3_launch_rst", 32'(core_reset), 3);
    tick();
    chk("t3_done", 32'(done), 1);
    chk("t3_no_start", 32'(core_start), 0);
    tick();
    chk("t3_done_hold", 32'(done), 1);
    start = 1'b0;
    tick();
    chk("t3_done_fall", 32'(done), 0);

    // simultaneous completion
    thread_count = 8'd8;
    start = 1'b1;
    repeat (3) tick();
    chk("t4_both_run", 32'(core_start), 3);
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    chk("t4_both_fin", 32'(core_start), 0);
    chk("t4_both_rst", 32'(core_reset), 3);
    chk("t4_done_lo", 32'(done), 0);
    tick();
    chk("t4_rst_1cyc", 32'(core_reset), 0);
    chk("t4_done_hi", 32'(done), 1);
    start = 1'b0;
    tick();

    // async reset in the middle of a kernel
    thread_count = 8'd8;
    start = 1'b1;
    repeat (3) tick();
    chk("t5_pre_run", 32'(core_start), 3);
    #1 reset = 1'b0;
    #1;
    chk("t5_async_start", 32'(core_start), 0);
    chk("t5_async_bid", 32'(core_block_id), 0);
    chk("t5_async_cnt", 32'(core_thread_count), 0);
    chk("t5_async_done", 32'(done), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk("t5_relaunch_rst", 32'(core_reset), 3);
    tick();
    chk("t5_re_c0", 32'(core_start), 1);
    chk("t5_re_bid0", 32'(core_block_id[0]), 0);
    tick();
    chk("t5_re_c1", 32'(core_start), 3);
    chk("t5_re_bid1", 32'(core_block_id[1]), 1);
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    tick();
    chk("t5_done", 32'(done), 1);
    start = 1'b0;
    tick();

    // tc=255 with core_done held high on every core, busy or not
    thread_count = 8'd255;
    start = 1'b1;
    tick();
    thread_count = 8'd3;
    core_done = '1;
    prev = '0;
    n_disp = 0;
    last_bid = -1;
    cnt62 = -1;
    cnt63 = -1;
    for (int c = 0; c < 600 && !done; c++) begin
      tick();
      for (int i = 0; i < NC; i++) begin
        if (core_start[i] && !prev[i]) begin
          n_disp++;
          last_bid = int'(core_block_id[i]);
          if (core_block_id[i] == 8'd62) cnt62 = int'(core_thread_count[i]);
          if (core_block_id[i] == 8'd63) cnt63 = int'(core_thread_count[i]);
        end
      end
      prev = core_start;
    end
    core_done = '0;
    chk("t6_done", 32'(done), 1);
    chk("t6_ndisp", 32'(n_disp), 64);
    chk("t6_last_bid", 32'(last_bid), 63);
    chk("t6_cnt62", 32'(cnt62), 4);
    chk("t6_cnt63", 32'(cnt63), 3);
    start = 1'b0;
    tick();
    chk("t6_done_fall", 32'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
